// File: rtl/el_t_src.sv
// rtl/el_t_src.sv - population-coded line source for threshold/majority elements
// Define EL_T_SRC_ROTATE_EN to rotate the active lines each cycle; otherwise a fixed thermometer code is driven.
module el_t_src #(
    parameter int OUT_NUM  = 3,
    parameter int CNT_W    = 8,
    parameter int HOLD_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   cnt_in,
    input  logic               cnt_valid,
    output logic               cnt_ready,
    output logic [OUT_NUM-1:0] out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        ptr_q, ptr_d;
    logic [15:0]        hold_q, hold_d;
    logic [CNT_W-1:0]   kk_q, kk_d;
    logic [OUT_NUM-1:0] out_q, out_d;
    logic [15:0]        ptr_nxt;
    logic [CNT_W-1:0]   cnt_sat;

    // Line i is active when its distance past ptr (wrapping) is below k.
    function automatic logic [OUT_NUM-1:0] line_pattern(input logic [15:0] p,
                                                        input logic [CNT_W-1:0] k);
        logic [31:0] off;
        line_pattern = '0;
        for (int i = 0; i < OUT_NUM; i++) begin
            if (32'(i) >= 32'(p))
                off = 32'(i) - 32'(p);
            else
                off = 32'(i) + 32'(OUT_NUM) - 32'(p);
            line_pattern[i] = (off < 32'(k));
        end
    endfunction

    assign cnt_sat = (32'(cnt_in) > 32'(OUT_NUM)) ? CNT_W'(OUT_NUM) : cnt_in;

`ifdef EL_T_SRC_ROTATE_EN
    assign ptr_nxt = (ptr_q == 16'(OUT_NUM - 1)) ? 16'd0 : ptr_q + 16'd1;
`else
    assign ptr_nxt = 16'd0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        kk_d    = kk_q;
        out_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (cnt_valid) begin
                    kk_d    = cnt_sat;
                    hold_d  = 16'(HOLD_CYC - 1);
                    out_d   = line_pattern(ptr_q, cnt_sat);
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                ptr_d = ptr_nxt;
                if (hold_q != 16'd0) begin
                    hold_d = hold_q - 16'd1;
                    out_d  = line_pattern(ptr_nxt, kk_q);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            kk_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            kk_q    <= kk_d;
            out_q   <= out_d;
        end
    end

    assign out       = out_q;
    assign cnt_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_DRIVE) || (state_q == S_DONE);
    assign done      = (state_q == S_DONE);

endmodule
